// File: rtl/vec_seq_ctrl_if.sv
// Purpose: bundles the decoder issue handshake, memory handshake and datapath controls of the vector sequencer.
// Latency: wires only, no state.
// Backpressure: issue_valid is held by the decoder until done/err; mem_req is held by the sequencer until mem_ack.
//
// Signals (master = decoder/memory side, slave = sequencer):
//   issue_valid/issue_ready  instruction handshake
//   dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_op, vl  decoded instruction fields
//   mem_ack                  memory completes current element
//   alu_op, elem_idx, elem_valid, wb_en  datapath controls
//   mem_req, mem_we          memory request and store qualifier
//   stall, done, err         fetch hold, retire pulse, timeout-abort pulse
interface vec_seq_ctrl_if #(
    parameter int IDX_W = 3
);
    logic             issue_valid;
    logic             issue_ready;
    logic             dec_reg_write;
    logic             dec_mem_read;
    logic             dec_mem_write;
    logic [2:0]       dec_alu_op;
    logic [IDX_W:0]   vl;
    logic             mem_ack;
    logic [2:0]       alu_op;
    logic [IDX_W-1:0] elem_idx;
    logic             elem_valid;
    logic             wb_en;
    logic             mem_req;
    logic             mem_we;
    logic             stall;
    logic             done;
    logic             err;

    modport master (
        output issue_valid, dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_op, vl, mem_ack,
        input  issue_ready, alu_op, elem_idx, elem_valid, wb_en, mem_req, mem_we, stall, done, err
    );

    modport slave (
        input  issue_valid, dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_op, vl, mem_ack,
        output issue_ready, alu_op, elem_idx, elem_valid, wb_en, mem_req, mem_we, stall, done, err
    );
endinterface

// File: rtl/vec_seq_ctrl.sv
// Purpose: steps one decoded vector instruction element by element, driving index, write-back and memory handshake.
// Latency: vl_eff+2 cycles issue-to-done for ALU ops and zero-wait memory ops; 2 cycles for vl=0.
// Backpressure: issue_ready only in IDLE; each memory element waits for mem_ack, aborting after TIMEOUT unacked cycles.
//
// Ports: clk, rst_n (async active-low) plus the slave side of vec_seq_ctrl_if (issue handshake,
// decoded fields, mem_ack in; alu_op, elem_idx, elem_valid, wb_en, mem_req, mem_we, stall, done, err out).
module vec_seq_ctrl #(
    parameter int VLEN    = 8,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    vec_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ALU  = 3'd1,
        S_MEM  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam int             CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0] VLEN_V    = (IDX_W + 1)'(VLEN);
    localparam logic [IDX_W:0] ONE_V     = (IDX_W + 1)'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   vl_q, vl_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic [IDX_W:0]   vl_eff;
    logic             last_elem;

    always_comb begin
        vl_eff    = (bus.vl > VLEN_V) ? VLEN_V : bus.vl;
        last_elem = ({1'b0, idx_q} == (vl_q - ONE_V));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            vl_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            alu_op_q    <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vl_q        <= vl_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            alu_op_q    <= alu_op_d;
            wait_q      <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vl_d        = vl_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        alu_op_d    = alu_op_q;
        wait_d      = wait_q;

        case (state_q)
            S_IDLE: begin
                if (bus.issue_valid) begin
                    reg_write_d = bus.dec_reg_write;
                    // A load+store encoding behaves as a store: the read flag is
                    // masked here so wb_en can never fire for it.
                    mem_read_d  = bus.dec_mem_read & ~bus.dec_mem_write;
                    mem_write_d = bus.dec_mem_write;
                    alu_op_d    = bus.dec_alu_op;
                    vl_d        = vl_eff;
                    idx_d       = '0;
                    wait_d      = '0;
                    if (vl_eff == '0) begin
                        state_d = S_DONE;
                    end else if (bus.dec_mem_read || bus.dec_mem_write) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_ALU;
                    end
                end
            end
            S_ALU: begin
                if (last_elem) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_MEM: begin
                // An ack on the final wait cycle takes priority over the abort.
                if (bus.mem_ack) begin
                    wait_d = '0;
                    if (last_elem) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state register so an async reset
    // clears them (and drops mem_req) without waiting for a clock edge.
    assign bus.issue_ready = (state_q == S_IDLE);
    assign bus.elem_valid  = (state_q == S_ALU) || (state_q == S_MEM);
    assign bus.mem_req     = (state_q == S_MEM);
    assign bus.mem_we      = (state_q == S_MEM) && mem_write_q;
    assign bus.wb_en       = ((state_q == S_ALU) && reg_write_q) ||
                             ((state_q == S_MEM) && bus.mem_ack && mem_read_q);
    assign bus.stall       = ((state_q == S_IDLE) && bus.issue_valid) ||
                             (state_q == S_ALU) || (state_q == S_MEM);
    assign bus.done        = (state_q == S_DONE);
    assign bus.err         = (state_q == S_ERR);
    assign bus.alu_op      = alu_op_q;
    assign bus.elem_idx    = idx_q;

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Purpose: scoreboard bench for vec_seq_ctrl; stimulus pushes expected events, a monitor pops and compares them.
// Latency: events carry the cycle number relative to the issue cycle (issue cycle = 1).
// Backpressure: a memory responder acks each request after a programmable number of extra cycles (-1 = never).
module tb_vec_seq_ctrl;

    localparam int K_WB   = 0;
    localparam int K_ACK  = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int kind;
        int idx;
        int aux;
        int nev;
        int alu;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    vec_seq_ctrl_if #(.IDX_W(3)) bus ();

    vec_seq_ctrl #(.VLEN(8), .IDX_W(3), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    ev_t   exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    ack_dly = 0;
    int    wcnt    = 0;
    int    t       = 0;
    int    scnt    = 0;
    int    ncnt    = 0;
    string cur_name = "init";

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d required %0d", cur_name, name, act, expv);
        end
    endtask

    task automatic push_ev(input int kind, input int idx, input int aux, input int nev,
                           input int alu, input int cyc);
        ev_t e;
        e.kind = kind; e.idx = idx; e.aux = aux; e.nev = nev; e.alu = alu; e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int aux, input int nev);
        ev_t e;
        int  a_idx;
        int  a_alu;
        a_idx = int'(bus.elem_idx);
        a_alu = int'(bus.alu_op);
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s/unexpected_event: got kind=%0d idx=%0d cyc=%0d, required no event",
                     cur_name, kind, a_idx, t);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.idx != a_idx || e.aux != aux || e.nev != nev ||
                e.alu != a_alu || e.cyc != t) begin
                n_fail++;
                $display("FAIL %s/event: got kind=%0d idx=%0d aux=%0d nev=%0d alu=%0d cyc=%0d required kind=%0d idx=%0d aux=%0d nev=%0d alu=%0d cyc=%0d",
                         cur_name, kind, a_idx, aux, nev, a_alu, t,
                         e.kind, e.idx, e.aux, e.nev, e.alu, e.cyc);
            end
        end
    endtask

    // Memory responder: ack after ack_dly extra cycles of an outstanding request.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.mem_req === 1'b1) begin
            if (ack_dly >= 0 && wcnt == ack_dly) begin
                bus.mem_ack = 1'b1;
                wcnt = 0;
            end else begin
                bus.mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Monitor: samples mid-low-phase, after the responder and driver have settled.
    always @(negedge clk) begin
        #1;
        if (rst_n !== 1'b1) begin
            t = 0; scnt = 0; ncnt = 0;
        end else begin
            if (bus.issue_valid && bus.issue_ready) begin
                t = 1;
                scnt = int'(bus.stall);
                ncnt = 0;
            end else begin
                t++;
                scnt += int'(bus.stall);
                ncnt += int'(bus.elem_valid);
            end
            if (bus.mem_req && bus.mem_ack) observe(K_ACK, int'(bus.mem_we), 0);
            if (bus.wb_en)                  observe(K_WB, 0, 0);
            if (bus.done)                   observe(K_DONE, scnt, ncnt);
            if (bus.err)                    observe(K_ERR, scnt, ncnt);
        end
    end

    // Pushes the expected event stream for one instruction, then drives it.
    // exp_end is the hand-computed cycle of the done/err pulse.
    task automatic run_op(input string name, input int vl, input bit rw, input bit rd,
                          input bit wr, input int alu, input int dly,
                          input int exp_end, input bit exp_err);
        int vle;
        int tc;
        int nev;
        int last;
        bit fin;
        vle  = (vl > 8) ? 8 : vl;
        tc   = 1;
        nev  = 0;
        last = 0;
        if (vle == 0) begin
            last = 0;
        end else if (!rd && !wr) begin
            for (int i = 0; i < vle; i++) begin
                tc++;
                nev++;
                if (rw) push_ev(K_WB, i, 0, 0, alu, tc);
                last = i;
            end
        end else begin
            for (int i = 0; i < vle; i++) begin
                last = i;
                if (dly < 0) begin
                    nev += 15;
                    break;
                end
                tc  += dly + 1;
                nev += dly + 1;
                push_ev(K_ACK, i, int'(wr), 0, alu, tc);
                if (rd && !wr) push_ev(K_WB, i, 0, 0, alu, tc);
            end
        end
        push_ev(exp_err ? K_ERR : K_DONE, last, exp_end - 1, nev, alu, exp_end);

        @(negedge clk);
        cur_name              = name;
        ack_dly               = dly;
        bus.dec_reg_write     = rw;
        bus.dec_mem_read      = rd;
        bus.dec_mem_write     = wr;
        bus.dec_alu_op        = 3'(alu);
        bus.vl                = 4'(vl);
        bus.issue_valid       = 1'b1;
        fin = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.err) begin
                fin = 1'b1;
                break;
            end
        end
        bus.issue_valid = 1'b0;
        chk("completed", int'(fin), 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bit found;
        rst_n             = 1'b0;
        bus.issue_valid   = 1'b0;
        bus.dec_reg_write = 1'b0;
        bus.dec_mem_read  = 1'b0;
        bus.dec_mem_write = 1'b0;
        bus.dec_alu_op    = 3'd0;
        bus.vl            = 4'd0;

        repeat (2) @(posedge clk);
        #2;
        cur_name = "reset";
        chk("issue_ready", int'(bus.issue_ready), 1);
        chk("elem_valid",  int'(bus.elem_valid), 0);
        chk("mem_req",     int'(bus.mem_req), 0);
        chk("stall",       int'(bus.stall), 0);
        chk("done",        int'(bus.done), 0);
        chk("elem_idx",    int'(bus.elem_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        //      name             vl rw rd wr alu dly end err
        run_op("alu_vl4",        4, 1, 0, 0, 5,  0,  6, 0);
        run_op("alu_nowb_vl3",   3, 0, 0, 0, 4,  0,  5, 0);
        run_op("load_vl3_d2",    3, 1, 1, 0, 2,  2, 11, 0);
        run_op("store_vl8",      8, 0, 0, 1, 1,  0, 10, 0);
        run_op("store_vl9",      9, 0, 0, 1, 7,  0, 10, 0);
        run_op("alu_vl0",        0, 1, 0, 0, 3,  0,  2, 0);
        run_op("load_vl0",       0, 1, 1, 0, 6,  0,  2, 0);
        run_op("load_timeout",   2, 1, 1, 0, 2, -1, 17, 1);
        run_op("load_ack15",     2, 1, 1, 0, 5, 14, 32, 0);
        run_op("ldst_as_store",  2, 1, 1, 1, 0,  0,  4, 0);

        // Reset in the middle of a memory op parked at element 2.
        cur_name = "reset_mid_mem";
        ack_dly  = 0;
        push_ev(K_ACK, 0, 0, 0, 3, 2);
        push_ev(K_WB,  0, 0, 0, 3, 2);
        push_ev(K_ACK, 1, 0, 0, 3, 3);
        push_ev(K_WB,  1, 0, 0, 3, 3);
        @(negedge clk);
        bus.dec_reg_write = 1'b1;
        bus.dec_mem_read  = 1'b1;
        bus.dec_mem_write = 1'b0;
        bus.dec_alu_op    = 3'd3;
        bus.vl            = 4'd4;
        bus.issue_valid   = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.elem_idx == 3'd2 && bus.mem_req) begin
                found = 1'b1;
                break;
            end
        end
        ack_dly = -1;
        chk("reach_idx2", int'(found), 1);
        repeat (2) @(posedge clk);
        #3;
        chk("idx_held", int'(bus.elem_idx), 2);
        chk("req_held", int'(bus.mem_req), 1);
        rst_n           = 1'b0;
        bus.issue_valid = 1'b0;
        #1;
        chk("mem_req_drop", int'(bus.mem_req), 0);
        chk("issue_ready",  int'(bus.issue_ready), 1);
        chk("elem_idx",     int'(bus.elem_idx), 0);
        chk("elem_valid",   int'(bus.elem_valid), 0);
        chk("stall",        int'(bus.stall), 0);
        chk("alu_op",       int'(bus.alu_op), 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op("alu_after_reset", 2, 1, 0, 0, 6, 0, 4, 0);

        cur_name = "end";
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_seq_ctrl.md
Name: vec_seq_ctrl

Overview:
- Multi-cycle sequencer between the vector instruction decoder and the vector datapath/data memory.
- Accepts one decoded vector instruction and steps it element by element over `vl` elements.
- Drives the per-element index, write-back strobe and memory request/acknowledge handshake.
- Holds the PC via `stall` until the instruction retires. Memory ops that receive no acknowledge are aborted by a timeout.

Parameters:
- VLEN, 8, maximum elements per vector register.
- IDX_W, 3, element index width (log2 VLEN).
- TIMEOUT, 15, maximum cycles to wait for `mem_ack` per element before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decoded instruction present; held until `done` or `err`.
- issue_ready  out  1  sequencer can accept an instruction.
- dec_reg_write  in  1  decoder register-write control.
- dec_mem_read  in  1  decoder load control.
- dec_mem_write  in  1  decoder store control.
- dec_alu_op  in  3  decoder ALU op.
- vl  in  IDX_W+1  requested vector length.
- mem_ack  in  1  data memory completes the current element access.
- alu_op  out  3  latched ALU op for the datapath.
- elem_idx  out  IDX_W  current element index.
- elem_valid  out  1  current element is active in the datapath.
- wb_en  out  1  register-file element write strobe.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (store) qualifier.
- stall  out  1  hold PC/fetch.
- done  out  1  one-cycle retire pulse.
- err  out  1  one-cycle timeout-abort pulse.

Behaviour:
- Reset: asynchronous, active-low. Takes effect immediately, including mid-operation.
  - State returns to IDLE; all registers clear.
  - `mem_req` drops with no wait for `mem_ack`.
  - All outputs are 0 except `issue_ready` = 1.
- States: IDLE, ALU, MEM, DONE, ERR.
- Effective length: vl_eff = min(vl, VLEN), latched at issue.
- IDLE:
  - `issue_ready` = 1.
  - When `issue_valid` = 1, latch `dec_*` and vl_eff, and clear `elem_idx`.
  - Next state: DONE if vl_eff = 0; else MEM if `dec_mem_read` or `dec_mem_write`; else ALU.
  - If both `dec_mem_read` and `dec_mem_write` are 1, the instruction is treated as a store and `wb_en` is never asserted.
- ALU:
  - `elem_valid` = 1; `wb_en` = latched `reg_write`; one element per cycle.
  - When `elem_idx` = vl_eff-1, go to DONE; else increment `elem_idx`.
- MEM:
  - `elem_valid` = 1; `mem_req` = 1; `mem_we` = latched `mem_write`.
  - `mem_req` and `elem_idx` stay stable until `mem_ack`.
  - A cycle with `mem_ack` = 1 completes the element: `wb_en` = latched `mem_read` in that same cycle, then increment the index or go to DONE on the last element.
  - The wait counter clears on each completed element and counts cycles with `mem_req` = 1 and `mem_ack` = 0.
  - When the counter reaches TIMEOUT, go to ERR. An ack arriving in that same cycle wins and the element completes normally.
  - `mem_ack` is ignored outside MEM.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE. `issue_valid` is ignored in this state.
- ERR: `err` = 1 for one cycle, then go to IDLE. Elements written before the abort are not rolled back.
- Stall: `stall` = (IDLE & `issue_valid`) | ALU | MEM. The PC therefore advances exactly once, on the DONE or ERR cycle.
- Latency:
  - ALU op: vl_eff + 2 cycles from issue to `done`.
  - vl = 0: 2 cycles (IDLE, DONE).
  - Memory op with zero-wait acks: vl_eff + 2 cycles.
- `alu_op` holds its latched value until the next issue. `elem_idx` holds its last value until the next issue.

Test Plan:
- ALU op, vl = 4, `reg_write` = 1 → `wb_en` high for 4 consecutive cycles with `elem_idx` 0,1,2,3; `done` on cycle 6; `stall` low only in DONE.
- Load, vl = 3, `mem_ack` returned 2 cycles after each request → `mem_req` held 3 cycles per element; `wb_en` only on ack cycles; `mem_we` = 0; `done` after 3 acks.
- Store, vl = 8 (and vl = 9 clamped to 8), ack tied to 1 → 8 requests with `mem_we` = 1, `wb_en` never high, `done` after `elem_idx` = 7.
- vl = 0 → no `elem_valid`; `done` pulse one cycle after issue; `stall` high for exactly 1 cycle.
- Load with no ack → `err` pulse after 15 wait cycles, then IDLE. Repeat with ack on cycle 15 → element completes, no `err`.
- `rst_n` asserted mid-MEM at `elem_idx` = 2 → `mem_req` drops immediately; `issue_ready` = 1; `elem_idx` = 0; next issue runs normally.
